fake_vpu_pipe: RTL and testbench

FAKE_VPU_PIPE -- requirements
Module: fake_vpu_pipe

---
 rtl/fake_vpu_pipe.sv | 149 ++++++++++++++
 tb/tb_fake_vpu_pipe.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fake_vpu_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fake_vpu_pipe
// Description : In-order issue/dispatch/completion tracker with credit return
//               for a vector unit stand-in; fixed ALU/MEM latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module fake_vpu_pipe #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 3,
    parameter int MEM_LAT = 5,
    parameter int SBID_W  = 5
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    issue_valid,
    input  logic [31:0]             issue_instr,
    input  logic [63:0]             issue_scalar,
    input  logic [SBID_W-1:0]       issue_sb_id,
    input  logic                    dispatch_valid,
    input  logic                    dispatch_kill,
    input  logic [SBID_W-1:0]       dispatch_sb_id,
    output logic                    issue_credit,
    output logic                    completed_valid,
    output logic [SBID_W-1:0]       completed_sb_id,
    output logic [63:0]             completed_dest_reg,
    output logic                    sync_start,
    output logic                    protocol_err,
    output logic [$clog2(DEPTH):0]  inflight
);

    localparam int c_PW      = $clog2(DEPTH);
    localparam int c_LAT_MAX = (ALU_LAT > MEM_LAT) ? ALU_LAT : MEM_LAT;
    localparam int c_TW      = $clog2(c_LAT_MAX + 1);
    // Timer is loaded with LAT-1 so a zero timer is seen exactly LAT cycles after dispatch.
    localparam logic [c_TW-1:0] c_ALU_LOAD = c_TW'(ALU_LAT - 1);
    localparam logic [c_TW-1:0] c_MEM_LOAD = c_TW'(MEM_LAT - 1);
    localparam logic [c_PW:0]   c_FULL     = (c_PW + 1)'(DEPTH);

    localparam logic [1:0] c_ST_INVALID    = 2'd0;
    localparam logic [1:0] c_ST_ISSUED     = 2'd1;
    localparam logic [1:0] c_ST_DISPATCHED = 2'd2;
    localparam logic [1:0] c_ST_KILLED     = 2'd3;

    logic [SBID_W-1:0] r_sb     [DEPTH];
    logic [63:0]       r_scalar [DEPTH];
    logic              r_mem    [DEPTH];
    logic [1:0]        r_state  [DEPTH];
    logic [c_TW-1:0]   r_timer  [DEPTH];
    logic [c_PW-1:0]   r_rd;
    logic [c_PW-1:0]   r_wr;
    logic [c_PW:0]     r_count;
    logic              r_err;

    logic              w_issue_acc;
    logic              w_issue_mem;
    logic              w_found;
    logic              w_tgt_new;
    logic [c_PW-1:0]   w_tgt;
    logic [c_PW-1:0]   w_idx;
    logic [SBID_W-1:0] w_tgt_sb;
    logic              w_tgt_mem;
    logic              w_disp_ok;
    logic              w_kill_head;
    logic              w_retire_done;
    logic              w_retire;
    logic              w_unused_instr;

    assign w_unused_instr = ^issue_instr[31:7];
    assign w_issue_acc    = issue_valid && (r_count != c_FULL);
    assign w_issue_mem    = (issue_instr[6:0] == 7'h07) || (issue_instr[6:0] == 7'h27);

    // Oldest ISSUED entry, scanning from the head; falls back to the entry arriving now.
    always_comb begin
        w_found   = 1'b0;
        w_tgt_new = 1'b0;
        w_tgt     = r_rd;
        w_idx     = r_rd;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rd + c_PW'(k);
            if (!w_found && (r_state[w_idx] == c_ST_ISSUED)) begin
                w_found = 1'b1;
                w_tgt   = w_idx;
            end
        end
        if (!w_found && w_issue_acc) begin
            w_found   = 1'b1;
            w_tgt_new = 1'b1;
            w_tgt     = r_wr;
        end
    end

    assign w_tgt_sb  = w_tgt_new ? issue_sb_id : r_sb[w_tgt];
    assign w_tgt_mem = w_tgt_new ? w_issue_mem : r_mem[w_tgt];
    assign w_disp_ok = dispatch_valid && w_found && (w_tgt_sb == dispatch_sb_id);

    // A head killed this cycle frees its slot immediately.
    assign w_kill_head   = w_disp_ok && dispatch_kill && (w_tgt == r_rd);
    assign w_retire_done = (r_state[r_rd] == c_ST_DISPATCHED) && (r_timer[r_rd] == '0);
    assign w_retire      = w_retire_done || w_kill_head || (r_state[r_rd] == c_ST_KILLED);

    assign issue_credit       = RST_N && w_retire;
    assign completed_valid    = RST_N && w_retire_done;
    assign completed_sb_id    = completed_valid ? r_sb[r_rd] : '0;
    assign completed_dest_reg = completed_valid ? r_scalar[r_rd] : '0;
    assign sync_start         = RST_N && w_disp_ok && !dispatch_kill && w_tgt_mem;
    assign protocol_err       = r_err;
    assign inflight           = r_count;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= c_ST_INVALID;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((r_state[i] == c_ST_DISPATCHED) && (r_timer[i] != '0)) begin
                    r_timer[i] <= r_timer[i] - c_TW'(1);
                end
            end
            if (w_issue_acc) begin
                r_sb[r_wr]     <= issue_sb_id;
                r_scalar[r_wr] <= issue_scalar;
                r_mem[r_wr]    <= w_issue_mem;
                r_state[r_wr]  <= c_ST_ISSUED;
                r_wr           <= r_wr + c_PW'(1);
            end
            if (w_disp_ok) begin
                r_state[w_tgt] <= dispatch_kill ? c_ST_KILLED : c_ST_DISPATCHED;
                r_timer[w_tgt] <= w_tgt_mem ? c_MEM_LOAD : c_ALU_LOAD;
            end
            if (w_retire) begin
                r_state[r_rd] <= c_ST_INVALID;
                r_rd          <= r_rd + c_PW'(1);
            end
            r_count <= r_count + (c_PW + 1)'(w_issue_acc) - (c_PW + 1)'(w_retire);
            if ((issue_valid && !w_issue_acc) || (dispatch_valid && !w_disp_ok)) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fake_vpu_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fake_vpu_pipe
// Description : Self-checking bench: directed vector table, wrap sequence and
//               randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fake_vpu_pipe;

    localparam int DEPTH   = 4;
    localparam int ALU_LAT = 3;
    localparam int MEM_LAT = 5;
    localparam int SBID_W  = 5;

    logic              CLK;
    logic              RST_N;
    logic              issue_valid;
    logic [31:0]       issue_instr;
    logic [63:0]       issue_scalar;
    logic [SBID_W-1:0] issue_sb_id;
    logic              dispatch_valid;
    logic              dispatch_kill;
    logic [SBID_W-1:0] dispatch_sb_id;
    logic              issue_credit;
    logic              completed_valid;
    logic [SBID_W-1:0] completed_sb_id;
    logic [63:0]       completed_dest_reg;
    logic              sync_start;
    logic              protocol_err;
    logic [2:0]        inflight;

    fake_vpu_pipe #(
        .DEPTH   (DEPTH),
        .ALU_LAT (ALU_LAT),
        .MEM_LAT (MEM_LAT),
        .SBID_W  (SBID_W)
    ) u_dut (
        .CLK                (CLK),
        .RST_N              (RST_N),
        .issue_valid        (issue_valid),
        .issue_instr        (issue_instr),
        .issue_scalar       (issue_scalar),
        .issue_sb_id        (issue_sb_id),
        .dispatch_valid     (dispatch_valid),
        .dispatch_kill      (dispatch_kill),
        .dispatch_sb_id     (dispatch_sb_id),
        .issue_credit       (issue_credit),
        .completed_valid    (completed_valid),
        .completed_sb_id    (completed_sb_id),
        .completed_dest_reg (completed_dest_reg),
        .sync_start         (sync_start),
        .protocol_err       (protocol_err),
        .inflight           (inflight)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst_n;
        logic        iv;
        logic [31:0] instr;
        logic [63:0] sc;
        logic [4:0]  sb;
        logic        dv;
        logic        kill;
        logic [4:0]  dsb;
        logic        cr;
        logic        cv;
        logic [4:0]  csb;
        logic [63:0] dest;
        logic        sync;
        logic        err;
        int          infl;
        logic        chk;
    } vec_t;

    typedef struct {
        logic        cr;
        logic        cv;
        logic [4:0]  csb;
        logic [63:0] dest;
        logic        sync;
        logic        err;
        int          infl;
    } obs_t;

    // Reference model: age-ordered queue, completion time kept as an absolute cycle.
    typedef struct {
        logic [4:0]  sb;
        logic [63:0] sc;
        bit          mem;
        int          st;      // 1 issued, 2 dispatched, 3 killed
        int          done;
    } ment_t;

    ment_t mq[$];
    bit    m_err;
    int    t;
    int    n_cmp;
    int    n_bad;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, act, exp, t);
        end
    endtask

    task automatic cmp_obs(input string tag, input obs_t a, input obs_t e, input logic full);
        chk({tag, "_credit"}, 64'(a.cr), 64'(e.cr));
        chk({tag, "_cvalid"}, 64'(a.cv), 64'(e.cv));
        chk({tag, "_csb"}, 64'(a.csb), 64'(e.csb));
        chk({tag, "_dest"}, a.dest, e.dest);
        chk({tag, "_sync"}, 64'(a.sync), 64'(e.sync));
        if (full) begin
            chk({tag, "_err"}, 64'(a.err), 64'(e.err));
            chk({tag, "_inflight"}, 64'(a.infl), 64'(e.infl));
        end
    endtask

    task automatic model_step(input vec_t v, output obs_t e);
        bit    acc;
        bit    nerr;
        int    idx;
        ment_t ne;
        e = '{default: 0};
        e.err  = m_err;
        e.infl = mq.size();
        if (!v.rst_n) begin
            mq.delete();
            m_err = 1'b0;
            return;
        end
        nerr = 1'b0;
        acc  = v.iv && (mq.size() < DEPTH);
        if (v.iv && !acc) nerr = 1'b1;
        if (acc) begin
            ne.sb   = v.sb;
            ne.sc   = v.sc;
            ne.mem  = (v.instr[6:0] == 7'h07) || (v.instr[6:0] == 7'h27);
            ne.st   = 1;
            ne.done = 0;
            mq.push_back(ne);
        end
        if (v.dv) begin
            idx = -1;
            foreach (mq[i]) if (idx < 0 && mq[i].st == 1) idx = i;
            if (idx < 0 || mq[idx].sb != v.dsb) nerr = 1'b1;
            else if (v.kill) mq[idx].st = 3;
            else begin
                mq[idx].st   = 2;
                mq[idx].done = t + (mq[idx].mem ? MEM_LAT : ALU_LAT);
                e.sync       = mq[idx].mem;
            end
        end
        if (mq.size() > 0 && (mq[0].st == 3 || (mq[0].st == 2 && t >= mq[0].done))) begin
            e.cr = 1'b1;
            if (mq[0].st == 2) begin
                e.cv   = 1'b1;
                e.csb  = mq[0].sb;
                e.dest = mq[0].sc;
            end
            void'(mq.pop_front());
        end
        if (nerr) m_err = 1'b1;
    endtask

    task automatic step(input vec_t v, output obs_t a, output obs_t m);
        RST_N          = v.rst_n;
        issue_valid    = v.iv;
        issue_instr    = v.instr;
        issue_scalar   = v.sc;
        issue_sb_id    = v.sb;
        dispatch_valid = v.dv;
        dispatch_kill  = v.kill;
        dispatch_sb_id = v.dsb;
        @(negedge CLK);
        a.cr   = issue_credit;
        a.cv   = completed_valid;
        a.csb  = completed_sb_id;
        a.dest = completed_dest_reg;
        a.sync = sync_start;
        a.err  = protocol_err;
        a.infl = int'(inflight);
        model_step(v, m);
        t++;
        @(posedge CLK);
        #1;
    endtask

    function automatic vec_t mk(input logic rst_n, iv, input logic [31:0] instr,
                                input logic [63:0] sc, input logic [4:0] sb,
                                input logic dv, kill, input logic [4:0] dsb,
                                input logic cr, cv, input logic [4:0] csb,
                                input logic [63:0] dest, input logic sync, err,
                                input int infl, input logic chkf);
        vec_t v;
        v.rst_n = rst_n; v.iv = iv; v.instr = instr; v.sc = sc; v.sb = sb;
        v.dv = dv; v.kill = kill; v.dsb = dsb; v.cr = cr; v.cv = cv; v.csb = csb;
        v.dest = dest; v.sync = sync; v.err = err; v.infl = infl; v.chk = chkf;
        return v;
    endfunction

    function automatic vec_t idl(input logic err, input int infl);
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, err, infl, 1);
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       vt[$];
        vec_t       v;
        obs_t       a;
        obs_t       m;
        obs_t       e;
        logic [4:0] iss[$];
        logic [4:0] tgt;
        int         n_disp;
        int         n_new;
        int         next_new;
        int         ncomp;
        int         idx;

        n_cmp = 0; n_bad = 0; t = 0; m_err = 1'b0;
        RST_N = 1'b0; issue_valid = 1'b0; issue_instr = '0; issue_scalar = '0;
        issue_sb_id = '0; dispatch_valid = 1'b0; dispatch_kill = 1'b0; dispatch_sb_id = '0;

        // reset with live-looking inputs: outputs must stay quiet
        vt.push_back(mk(0, 1, 'h07, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 'h07, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 1, 'h07, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        // single ALU op sb 3
        vt.push_back(mk(1, 1, 'h13, 'h55, 3, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1));
        vt.push_back(idl(0, 1));
        vt.push_back(idl(0, 1));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 'h55, 0, 0, 1, 1));
        // MEM sb 1 then ALU sb 2: in-order completion
        vt.push_back(mk(1, 1, 'h07, 'hA1, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1));
        vt.push_back(mk(1, 1, 'h33, 'hB2, 2, 1, 0, 2, 0, 0, 0, 0, 0, 0, 1, 1));
        vt.push_back(idl(0, 2));
        vt.push_back(idl(0, 2));
        vt.push_back(idl(0, 2));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'hA1, 0, 0, 2, 1));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 'hB2, 0, 0, 1, 1));
        // kill sb 4
        vt.push_back(mk(1, 1, 'h13, 'h44, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vt.push_back(idl(0, 1));
        vt.push_back(mk(1, 0, 0, 0, 0, 1, 1, 4, 1, 0, 0, 0, 0, 0, 1, 1));
        // sb mismatch leaves entry issued
        vt.push_back(mk(1, 1, 'h13, 'h77, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 0, 1, 0, 8, 0, 0, 0, 0, 0, 0, 1, 1));
        vt.push_back(mk(1, 0, 0, 0, 0, 1, 0, 7, 0, 0, 0, 0, 0, 1, 1, 1));
        vt.push_back(idl(1, 1));
        vt.push_back(idl(1, 1));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 'h77, 0, 1, 1, 1));
        vt.push_back(idl(1, 0));
        // reset with three in flight, one due to complete during reset
        vt.push_back(mk(1, 1, 'h13, 9, 9, 1, 0, 9, 0, 0, 0, 0, 0, 1, 0, 1));
        vt.push_back(mk(1, 1, 'h13, 10, 10, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        vt.push_back(mk(1, 1, 'h13, 11, 11, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1));
        for (int i = 0; i < 4; i++) vt.push_back(idl(0, 0));

        foreach (vt[i]) begin
            step(vt[i], a, m);
            e.cr = vt[i].cr; e.cv = vt[i].cv; e.csb = vt[i].csb; e.dest = vt[i].dest;
            e.sync = vt[i].sync; e.err = vt[i].err; e.infl = vt[i].infl;
            cmp_obs($sformatf("vec%0d", i), a, e, vt[i].chk);
        end

        // fill, overflow, then stream 12 more through the wrapping pointers
        for (int i = 0; i < 4; i++) begin
            v = mk(1, 1, 'h13, 64'h100 + 64'(i), 5'(10 + i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            iss.push_back(5'(10 + i));
            step(v, a, m);
            cmp_obs("fill", a, m, 1);
            chk("fill_inflight", 64'(a.infl), 64'(i));
        end
        v = mk(1, 1, 'h13, 'h1FF, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(v, a, m);
        chk("drop_inflight", 64'(a.infl), 64'd4);
        chk("drop_err_before", 64'(a.err), 64'd0);
        step(idl(0, 0), a, m);
        chk("drop_err", 64'(a.err), 64'd1);
        chk("drop_inflight_after", 64'(a.infl), 64'd4);

        n_disp = 0; n_new = 0; next_new = 15; ncomp = 0;
        for (int c = 0; c < 200 && ncomp < 16; c++) begin
            v = idl(0, 0);
            if (n_new < 12 && mq.size() < DEPTH) begin
                v.iv    = 1'b1;
                v.sb    = 5'(next_new);
                v.sc    = 64'h200 + 64'(next_new);
                v.instr = (n_new % 3 == 0) ? 32'h27 : 32'h33;
                iss.push_back(5'(next_new));
                next_new++;
                n_new++;
            end
            if (n_disp < iss.size()) begin
                v.dv  = 1'b1;
                v.dsb = iss[n_disp];
                n_disp++;
            end
            step(v, a, m);
            cmp_obs("wrap", a, m, 1);
            if (a.cv) begin
                chk("wrap_order", 64'(a.csb), 64'(iss[ncomp]));
                ncomp++;
            end
        end
        chk("wrap_all_completed", 64'(ncomp), 64'd16);

        // randomized traffic with occasional resets
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), a, m);
        for (int c = 0; c < 600; c++) begin
            v = idl(0, 0);
            v.rst_n = ($urandom_range(0, 99) != 0);
            v.iv    = 1'($urandom_range(0, 1));
            v.instr = $urandom();
            case ($urandom_range(0, 3))
                0: v.instr[6:0] = 7'h07;
                1: v.instr[6:0] = 7'h27;
                2: v.instr[6:0] = 7'h13;
                default: v.instr[6:0] = 7'h33;
            endcase
            v.sc   = {$urandom(), $urandom()};
            v.sb   = 5'($urandom_range(0, 31));
            v.dv   = ($urandom_range(0, 2) != 0);
            v.kill = ($urandom_range(0, 4) == 0);
            idx = -1;
            foreach (mq[i]) if (idx < 0 && mq[i].st == 1) idx = i;
            if (idx >= 0) tgt = mq[idx].sb;
            else if (v.iv && mq.size() < DEPTH) tgt = v.sb;
            else tgt = 5'($urandom_range(0, 31));
            v.dsb = ($urandom_range(0, 9) < 8) ? tgt : 5'($urandom_range(0, 31));
            step(v, a, m);
            cmp_obs("rand", a, m, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
